// File: rtl/producer.sv
// ---------------------------------------------------------------------------
// producer
//   Transmit end of a ready/ack parallel handshake. Upstream logic pushes
//   words into a small FIFO. The block offers the words one at a time on
//   pdata_o with ready_o high, and holds each word stable until the consumer
//   returns a one-cycle ack_i pulse. It counts completed transfers and keeps
//   sticky flags for spurious acknowledgements and stalled offers.
//
// Ports
//   clk          clock
//   rst_l        asynchronous active-low reset
//   wr_en_i      push request from upstream
//   wr_data_i    word to push (N bits)
//   full_o       FIFO holds DEPTH words
//   level_o      current FIFO occupancy (0..DEPTH)
//   ready_o      pdata_o valid, offered to consumer
//   ack_i        consumer acknowledge pulse
//   pdata_o      offered word (N bits)
//   sent_cnt_o   completed transfers, wraps at 16 bits
//   err_proto_o  sticky: ack_i seen while ready_o low
//   err_timeout_o sticky: an offer waited TIMEOUT cycles without ack
//   clr_err_i    synchronous clear of both error flags
// ---------------------------------------------------------------------------
module producer #(
  parameter int N       = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst_l,
  input  logic                     wr_en_i,
  input  logic [N-1:0]             wr_data_i,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     ready_o,
  input  logic                     ack_i,
  output logic [N-1:0]             pdata_o,
  output logic [15:0]              sent_cnt_o,
  output logic                     err_proto_o,
  output logic                     err_timeout_o,
  input  logic                     clr_err_i
);

  localparam int AW = $clog2(DEPTH);
  // A disabled timeout still needs a legal one-bit counter.
  localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [AW:0]   LEVEL_FULL = (AW + 1)'(DEPTH);
  localparam logic [WW-1:0] WAIT_LIMIT = WW'(TIMEOUT);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    mem [DEPTH];
  logic [AW-1:0]   wrPtr_q, wrPtr_d;
  logic [AW-1:0]   rdPtr_q, rdPtr_d;
  logic [AW:0]     level_q, level_d;
  logic [N-1:0]    pdata_q, pdata_d;
  logic [15:0]     sentCnt_q, sentCnt_d;
  logic [WW-1:0]   waitCnt_q, waitCnt_d;
  logic            errProto_q, errProto_d;
  logic            errTimeout_q, errTimeout_d;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;

  // Full/empty come from the registered level, so a push while full is
  // rejected even when a pop happens on the same edge.
  assign full  = (level_q == LEVEL_FULL);
  assign empty = (level_q == '0);
  assign push  = wr_en_i && !full;

  // Next-state logic for the offer FSM, the counters and the error flags.
  always_comb begin
    state_d      = state_q;
    pdata_d      = pdata_q;
    sentCnt_d    = sentCnt_q;
    waitCnt_d    = waitCnt_q;
    errProto_d   = errProto_q;
    errTimeout_d = errTimeout_q;
    pop          = 1'b0;

    // Clear first so that a set condition below overrides it.
    if (clr_err_i) begin
      errProto_d   = 1'b0;
      errTimeout_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (ack_i) begin
          errProto_d = 1'b1;
        end
        if (!empty) begin
          pop       = 1'b1;
          pdata_d   = mem[rdPtr_q];
          waitCnt_d = '0;
          state_d   = OFFER;
        end
      end
      OFFER: begin
        if (ack_i) begin
          sentCnt_d = sentCnt_q + 16'd1;
          if (!empty) begin
            pop       = 1'b1;
            pdata_d   = mem[rdPtr_q];
            waitCnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (waitCnt_q != WAIT_LIMIT) begin
            waitCnt_d = waitCnt_q + 1'b1;
          end
          if ((TIMEOUT > 0) && (waitCnt_d == WAIT_LIMIT)) begin
            errTimeout_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO pointer and occupancy bookkeeping; pointers wrap naturally since
  // DEPTH is a power of two.
  always_comb begin
    wrPtr_d = push ? wrPtr_q + 1'b1 : wrPtr_q;
    rdPtr_d = pop  ? rdPtr_q + 1'b1 : rdPtr_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // FIFO storage has no reset; stale entries are unreachable once the
  // pointers and level are cleared.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wrPtr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q      <= IDLE;
      wrPtr_q      <= '0;
      rdPtr_q      <= '0;
      level_q      <= '0;
      pdata_q      <= '0;
      sentCnt_q    <= '0;
      waitCnt_q    <= '0;
      errProto_q   <= 1'b0;
      errTimeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wrPtr_q      <= wrPtr_d;
      rdPtr_q      <= rdPtr_d;
      level_q      <= level_d;
      pdata_q      <= pdata_d;
      sentCnt_q    <= sentCnt_d;
      waitCnt_q    <= waitCnt_d;
      errProto_q   <= errProto_d;
      errTimeout_q <= errTimeout_d;
    end
  end

  assign full_o        = full;
  assign level_o       = level_q;
  assign ready_o       = (state_q == OFFER);
  assign pdata_o       = pdata_q;
  assign sent_cnt_o    = sentCnt_q;
  assign err_proto_o   = errProto_q;
  assign err_timeout_o = errTimeout_q;

endmodule

// File: tb/tb_producer.sv
// ---------------------------------------------------------------------------
// tb_producer
//   Directed testbench for producer with hand-computed expected values.
// ---------------------------------------------------------------------------
module tb_producer;

  logic        clk;
  logic        rst_l;
  logic        wrEn;
  logic [7:0]  wrData;
  logic        full;
  logic [2:0]  level;
  logic        ready;
  logic        ack;
  logic [7:0]  pdata;
  logic [15:0] sentCnt;
  logic        errProto;
  logic        errTimeout;
  logic        clrErr;

  int vectorCount;
  int miscompareCount;

  producer #(.N(8), .DEPTH(4), .TIMEOUT(16)) dut (
    .clk           (clk),
    .rst_l         (rst_l),
    .wr_en_i       (wrEn),
    .wr_data_i     (wrData),
    .full_o        (full),
    .level_o       (level),
    .ready_o       (ready),
    .ack_i         (ack),
    .pdata_o       (pdata),
    .sent_cnt_o    (sentCnt),
    .err_proto_o   (errProto),
    .err_timeout_o (errTimeout),
    .clr_err_i     (clrErr)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value and log misses.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      miscompareCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, let one rising edge happen, then settle.
  task automatic applyStimulus(input logic w, input logic [7:0] d,
                               input logic a, input logic c);
    wrEn   = w;
    wrData = d;
    ack    = a;
    clrErr = c;
    @(posedge clk);
    #2;
  endtask

  logic       expReady [1:8];
  logic [7:0] expPdata [1:8];

  // Main directed sequence.
  initial begin
    vectorCount     = 0;
    miscompareCount = 0;
    rst_l  = 1'b0;
    wrEn   = 1'b0;
    wrData = 8'h00;
    ack    = 1'b0;
    clrErr = 1'b0;
    expReady = '{1, 1, 1, 1, 1, 1, 1, 0};
    expPdata = '{8'h01, 8'h02, 8'h02, 8'h03, 8'h03, 8'h04, 8'h04, 8'h00};

    @(posedge clk);
    #2;
    checkOutput("rst_ready", ready, 0);
    checkOutput("rst_pdata", pdata, 0);
    checkOutput("rst_level", level, 0);
    checkOutput("rst_full", full, 0);
    checkOutput("rst_sent", sentCnt, 0);
    checkOutput("rst_errp", errProto, 0);
    checkOutput("rst_errt", errTimeout, 0);
    rst_l = 1'b1;

    $display("[TB] single word");
    applyStimulus(1, 8'hA5, 0, 0);
    checkOutput("sw_level_push", level, 1);
    checkOutput("sw_ready_push", ready, 0);
    applyStimulus(0, 8'h00, 0, 0);
    checkOutput("sw_ready", ready, 1);
    checkOutput("sw_pdata", pdata, 8'hA5);
    checkOutput("sw_level", level, 0);
    applyStimulus(0, 8'h00, 1, 0);
    checkOutput("sw_ready_done", ready, 0);
    checkOutput("sw_sent", sentCnt, 1);
    checkOutput("sw_level_done", level, 0);

    $display("[TB] back-to-back");
    for (int e = 0; e <= 8; e++) begin
      applyStimulus(e < 4, 8'(e + 1), (e == 2) || (e == 4) || (e == 6) || (e == 8), 0);
      if (e >= 1) begin
        checkOutput($sformatf("b2b_ready_e%0d", e), ready, expReady[e]);
        if (expReady[e]) begin
          checkOutput($sformatf("b2b_pdata_e%0d", e), pdata, expPdata[e]);
        end
      end
    end
    checkOutput("b2b_sent", sentCnt, 5);

    $display("[TB] overflow");
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1, 8'(8'h10 + k), 0, 0);
    end
    wrEn = 1'b0;
    checkOutput("ovf_level", level, 4);
    checkOutput("ovf_full", full, 1);
    checkOutput("ovf_pdata", pdata, 8'h10);
    applyStimulus(1, 8'hEE, 0, 0);
    checkOutput("ovf_drop_level", level, 4);
    for (int w = 0; w < 5; w++) begin
      checkOutput($sformatf("ovf_ready_w%0d", w), ready, 1);
      checkOutput($sformatf("ovf_pdata_w%0d", w), pdata, 8'h10 + w);
      applyStimulus(0, 8'h00, 1, 0);
      applyStimulus(0, 8'h00, 0, 0);
    end
    checkOutput("ovf_ready_end", ready, 0);
    checkOutput("ovf_level_end", level, 0);
    checkOutput("ovf_sent", sentCnt, 10);
    checkOutput("ovf_errt", errTimeout, 0);

    $display("[TB] stall and timeout");
    applyStimulus(1, 8'h3C, 0, 0);
    applyStimulus(0, 8'h00, 0, 0);
    checkOutput("to_ready", ready, 1);
    for (int c = 0; c < 15; c++) begin
      applyStimulus(0, 8'h00, 0, 0);
    end
    checkOutput("to_errt_15", errTimeout, 0);
    applyStimulus(0, 8'h00, 0, 0);
    checkOutput("to_errt_16", errTimeout, 1);
    checkOutput("to_pdata", pdata, 8'h3C);
    checkOutput("to_ready_held", ready, 1);
    applyStimulus(0, 8'h00, 1, 0);
    checkOutput("to_ready_done", ready, 0);
    checkOutput("to_sent", sentCnt, 11);
    checkOutput("to_errt_sticky", errTimeout, 1);
    applyStimulus(0, 8'h00, 0, 1);
    checkOutput("to_errt_clr", errTimeout, 0);

    $display("[TB] spurious ack");
    applyStimulus(0, 8'h00, 1, 0);
    checkOutput("sp_errp", errProto, 1);
    checkOutput("sp_sent", sentCnt, 11);
    checkOutput("sp_level", level, 0);
    checkOutput("sp_ready", ready, 0);
    applyStimulus(0, 8'h00, 1, 1);
    checkOutput("sp_errp_setwins", errProto, 1);
    applyStimulus(0, 8'h00, 0, 1);
    checkOutput("sp_errp_clr", errProto, 0);

    $display("[TB] reset mid-offer");
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 8'(8'h50 + k), 0, 0);
    end
    wrEn = 1'b0;
    checkOutput("rm_ready", ready, 1);
    checkOutput("rm_level", level, 3);
    rst_l = 1'b0;
    #1;
    checkOutput("rm_ready_async", ready, 0);
    checkOutput("rm_pdata_async", pdata, 0);
    checkOutput("rm_level_async", level, 0);
    checkOutput("rm_sent_async", sentCnt, 0);
    applyStimulus(0, 8'h00, 0, 0);
    applyStimulus(0, 8'h00, 0, 0);
    rst_l = 1'b1;
    for (int c = 0; c < 3; c++) begin
      applyStimulus(0, 8'h00, 0, 0);
    end
    checkOutput("rm_ready_quiet", ready, 0);
    checkOutput("rm_level_quiet", level, 0);
    applyStimulus(1, 8'h77, 0, 0);
    applyStimulus(0, 8'h00, 0, 0);
    checkOutput("rm_ready_new", ready, 1);
    checkOutput("rm_pdata_new", pdata, 8'h77);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
    $finish;
  end

endmodule
